vend_credit_ctrl: RTL and testbench
===================================

Name: vend_credit_ctrl

Overview:
- Controller FSM for the vending machine's 5-bit credit register.
- Accepts coin events and adds their value to the stored credit.
- On a valid selection it issues a vend, subtracts the price, then pays the remaining credit back as change, one unit per cycle.
- Sits between the coin acceptor/keypad front-end and the dispenser/change hopper drivers. It is the only writer of the credit register.

Parameters:
- PRICE, 15, item price in credit units (1 unit = 5 cents); legal range 1..31.
- CREDIT_W, 5, credit register width; max credit = 2^CREDIT_W-1 = 31.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- coin_valid  input  1  one-cycle strobe: a coin is present this cycle.
- coin_type  input  2  00=1 unit, 01=2 units, 10=5 units, 11=unrecognised.
- select  input  1  one-cycle strobe: user requests the item.
- cancel  input  1  one-cycle strobe: user requests a refund.
- credit  output  CREDIT_W  current stored credit (register Q).
- vend  output  1  one-cycle pulse: dispense item.
- change_pulse  output  1  one pulse per credit unit returned.
- coin_reject  output  1  one-cycle pulse: return the coin just inserted.
- busy  output  1  high in VEND and CHANGE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, credit=0, vend=0, change_pulse=0, coin_reject=0, busy=0.
  - Applies immediately, including mid-CHANGE. Any unpaid change is discarded.
- All outputs are registered. A response appears the cycle after the triggering edge.
- States:
  - IDLE: credit==0.
  - COLLECT: credit>0, accepting coins.
  - VEND: exactly 1 cycle.
  - CHANGE: paying out.
- Coin handling (IDLE/COLLECT only):
  - sum = credit + value, computed CREDIT_W+1 bits wide.
  - If sum<=31 and coin_type!=11: credit<=sum, and go to COLLECT.
  - Otherwise: coin_reject=1 for one cycle, and credit is unchanged.
- Priority when strobes coincide in IDLE/COLLECT: cancel > select > coin. A coin that loses arbitration is rejected (coin_reject=1) and never counted.
- select:
  - If credit>=PRICE: go to VEND.
  - If credit<PRICE: no effect, no pulse.
- cancel:
  - In COLLECT: go to CHANGE and refund the full credit.
  - In IDLE: no effect.
- VEND:
  - vend=1 for one cycle, busy=1, credit<=credit-PRICE.
  - Next state is CHANGE if the result is >0, else IDLE.
- CHANGE:
  - Each cycle: change_pulse=1 and credit<=credit-1.
  - When credit reaches 0, go to IDLE. Pulses stop the cycle credit reads 0.
  - N units of change produce exactly N consecutive pulses.
- In VEND/CHANGE: every coin_valid gives coin_reject=1. select and cancel are ignored.
- Credit never wraps. Add is overflow-guarded; subtracts only occur when credit>=PRICE or credit>0.
- Credit register writes use the register's en/d interface. en is asserted only on an accepted coin, a VEND cycle or a CHANGE cycle.

Decomposition:
- Shared package vm_pkg holds:
  - state encoding localparams: IDLE=2'd0, COLLECT=2'd1, VEND=2'd2, CHANGE=2'd3.
  - coin code localparams: COIN_1, COIN_2, COIN_5, COIN_BAD.
  - coin value constants: 1, 2, 5.
- One sub-module, vm_credit_reg: a CREDIT_W-bit register with en/d/q and asynchronous active-low clear. It is instantiated once. The FSM and next-credit arithmetic stay in vend_credit_ctrl.

Test Plan (PRICE=15):
- Three COIN_5 strobes -> credit 5,10,15; then select -> vend high exactly 1 cycle, credit 0, IDLE, zero change_pulse.
- COIN_5 x4 plus COIN_2 -> credit 22; select -> vend 1 cycle, credit 7, then exactly 7 consecutive change_pulse cycles, credit 0, IDLE.
- Credit 30, COIN_2 -> coin_reject 1 cycle, credit stays 30; then COIN_1 -> credit 31. COIN_BAD at any credit -> reject, credit unchanged.
- Credit 6, cancel -> no vend, 6 change_pulse cycles, IDLE. Credit 14, select -> no vend, credit stays 14.
- Credit 15, select and coin_valid(COIN_1) in same cycle -> vend, coin_reject, credit 0. Coin during CHANGE -> coin_reject, credit sequence unaffected.
- Credit 22, select, then rst_n low after 3 change pulses -> outputs and credit 0 asynchronously; after release, IDLE and new coins accepted.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared constants for the vending machine credit controller:
// FSM state encoding, coin codes and coin values.
package vm_pkg;

    typedef logic [1:0] state_t;

    // FSM state encoding
    localparam state_t IDLE    = 2'd0;
    localparam state_t COLLECT = 2'd1;
    localparam state_t VEND    = 2'd2;
    localparam state_t CHANGE  = 2'd3;

    // Coin codes as presented by the coin acceptor
    localparam logic [1:0] COIN_1   = 2'b00;
    localparam logic [1:0] COIN_2   = 2'b01;
    localparam logic [1:0] COIN_5   = 2'b10;
    localparam logic [1:0] COIN_BAD = 2'b11;

    // Coin values in credit units (1 unit = 5 cents)
    localparam logic [2:0] COIN_1_VAL = 3'd1;
    localparam logic [2:0] COIN_2_VAL = 3'd2;
    localparam logic [2:0] COIN_5_VAL = 3'd5;

    // Value of a coin code; an unrecognised coin is worth nothing.
    function automatic logic [2:0] coin_value(input logic [1:0] code);
        logic [2:0] val;
        case (code)
            COIN_1:  val = COIN_1_VAL;
            COIN_2:  val = COIN_2_VAL;
            COIN_5:  val = COIN_5_VAL;
            default: val = 3'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vm_credit_reg.sv
// Credit register: W-bit storage with a write enable and an
// asynchronous active-low clear.
module vm_credit_reg #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load d when enabled; clear immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending machine credit controller. Accumulates coin credit, issues a
// vend when the item is paid for, then pays remaining credit back as
// change one unit per cycle. All outputs are registered.
//
// Strobe semantics: coin_valid, select and cancel are single-cycle
// strobes sampled on the rising clock edge; there is no back-pressure.
// Every response (vend, change_pulse, coin_reject) is a one-cycle pulse
// visible in the cycle after the edge that caused it.
module vend_credit_ctrl
    import vm_pkg::*;
#(
    parameter int PRICE    = 15,
    parameter int CREDIT_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                select,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                busy
);

    localparam int                  SW      = CREDIT_W + 1;
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

    state_t              state_q, state_d;
    logic                vend_q, change_pulse_q, coin_reject_q, busy_q;
    logic                reject_d;
    logic                credit_en;
    logic [CREDIT_W-1:0] credit_d;
    logic [CREDIT_W-1:0] credit_q;
    logic [SW-1:0]       coin_sum;
    logic                coin_ok;

    // The credit register is the single point of storage for credit.
    vm_credit_reg #(
        .W (CREDIT_W)
    ) u_credit_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (credit_en),
        .d     (credit_d),
        .q     (credit_q)
    );

    // Next-state, next-credit and coin accept/reject decision.
    always_comb begin
        state_d   = state_q;
        credit_en = 1'b0;
        credit_d  = credit_q;
        reject_d  = 1'b0;

        // One bit wider than the register so overflow is visible in the MSB.
        coin_sum = {1'b0, credit_q} + SW'(coin_value(coin_type));
        coin_ok  = (coin_type != COIN_BAD) && !coin_sum[CREDIT_W];

        case (state_q)
            IDLE, COLLECT: begin
                // cancel > select > coin. Any asserted cancel or select
                // wins the cycle, so a simultaneous coin is handed back.
                if (cancel) begin
                    reject_d = coin_valid;
                    if (state_q == COLLECT) begin
                        state_d = CHANGE;
                    end
                end else if (select) begin
                    reject_d = coin_valid;
                    if (credit_q >= PRICE_C) begin
                        state_d = VEND;
                    end
                end else if (coin_valid) begin
                    if (coin_ok) begin
                        credit_en = 1'b1;
                        credit_d  = coin_sum[CREDIT_W-1:0];
                        state_d   = COLLECT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            VEND: begin
                // Entry required credit >= PRICE, so this cannot underflow.
                reject_d  = coin_valid;
                credit_en = 1'b1;
                credit_d  = credit_q - PRICE_C;
                state_d   = (credit_q != PRICE_C) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_d = coin_valid;
                if (credit_q != '0) begin
                    credit_en = 1'b1;
                    credit_d  = credit_q - ONE_C;
                    state_d   = (credit_q == ONE_C) ? IDLE : CHANGE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered output pulses, decoded from the next state so
    // each pulse lines up with the cycle spent in the matching state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            vend_q         <= 1'b0;
            change_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            vend_q         <= (state_d == VEND);
            change_pulse_q <= (state_d == CHANGE);
            coin_reject_q  <= reject_d;
            busy_q         <= (state_d == VEND) || (state_d == CHANGE);
        end
    end

    assign credit       = credit_q;
    assign vend         = vend_q;
    assign change_pulse = change_pulse_q;
    assign coin_reject  = coin_reject_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Bench for vend_credit_ctrl. A reference model turns each cycle's
// stimulus into the expected output frame and queues it; a monitor on
// the falling edge pops and compares every cycle.
module tb_vend_credit_ctrl;
  import vm_pkg::*;

  localparam int PRICE    = 15;
  localparam int CREDIT_W = 5;
  localparam int MAXC     = (1 << CREDIT_W) - 1;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                coin_valid = 1'b0;
  logic [1:0]          coin_type = 2'b00;
  logic                select = 1'b0;
  logic                cancel = 1'b0;
  logic [CREDIT_W-1:0] credit;
  logic                vend, change_pulse, coin_reject, busy;

  always #5 clk = ~clk;

  vend_credit_ctrl #(
    .PRICE    (PRICE),
    .CREDIT_W (CREDIT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .select       (select),
    .cancel       (cancel),
    .credit       (credit),
    .vend         (vend),
    .change_pulse (change_pulse),
    .coin_reject  (coin_reject),
    .busy         (busy)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [CREDIT_W-1:0] credit;
    logic                vend;
    logic                chg;
    logic                rej;
    logic                busy;
  } frame_t;

  localparam int FW = $bits(frame_t);

  logic [FW-1:0] exp_q[$];
  frame_t        plan[$];    // scripted frames of a vend/refund sequence
  frame_t        cur = '0;   // frame the DUT is expected to show now
  int            n_checks = 0;
  int            n_pass = 0;
  bit            mon_en = 1'b0;

  function automatic frame_t mk(int c, bit v, bit ch, bit b);
    frame_t f;
    f.credit = CREDIT_W'(c);
    f.vend   = v;
    f.chg    = ch;
    f.rej    = 1'b0;
    f.busy   = b;
    return f;
  endfunction

  function automatic int coin_units(logic [1:0] t);
    case (t)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 5;
      default: return 0;
    endcase
  endfunction

  // Script for paying out r units: r pulse cycles counting down, then idle at 0.
  task automatic script_payout(int r);
    for (int k = r; k >= 1; k--) plan.push_back(mk(k, 1'b0, 1'b1, 1'b1));
    plan.push_back(mk(0, 1'b0, 1'b0, 1'b0));
  endtask

  // Drive one cycle of inputs and queue the frame expected after the next edge.
  task automatic drive_step(bit cv, logic [1:0] ct, bit sel, bit can);
    frame_t nxt;
    int     c;
    coin_valid = cv;
    coin_type  = ct;
    select     = sel;
    cancel     = can;
    c = int'(cur.credit);
    if (cur.busy) begin
      nxt = (plan.size() > 0) ? plan.pop_front() : mk(0, 1'b0, 1'b0, 1'b0);
      nxt.rej = cv;
    end else if (can) begin
      nxt = mk(c, 1'b0, 1'b0, 1'b0);
      if (c > 0) begin
        script_payout(c);
        nxt = plan.pop_front();
      end
      nxt.rej = cv;
    end else if (sel) begin
      nxt = mk(c, 1'b0, 1'b0, 1'b0);
      if (c >= PRICE) begin
        plan.push_back(mk(c, 1'b1, 1'b0, 1'b1));
        script_payout(c - PRICE);
        nxt = plan.pop_front();
      end
      nxt.rej = cv;
    end else begin
      nxt = mk(c, 1'b0, 1'b0, 1'b0);
      if (cv) begin
        if (ct == COIN_BAD || c + coin_units(ct) > MAXC) nxt.rej = 1'b1;
        else nxt.credit = CREDIT_W'(c + coin_units(ct));
      end
    end
    cur = nxt;
    exp_q.push_back(nxt);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(bit cv, logic [1:0] ct, bit sel, bit can);
    @(posedge clk);
    #2;
    drive_step(cv, ct, sel, can);
  endtask

  task automatic coin(logic [1:0] ct);
    cyc(1'b1, ct, 1'b0, 1'b0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  // Reset lands mid-cycle, away from the clock edge, so the frame due at
  // the coming falling edge is already all-zero; one edge passes in reset.
  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst_n      = 1'b0;
    coin_valid = 1'b0;
    select     = 1'b0;
    cancel     = 1'b0;
    exp_q.delete();
    plan.delete();
    cur = '0;
    exp_q.push_back('0);
    exp_q.push_back('0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive_step(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      frame_t e;
      frame_t a;
      a = {credit, vend, change_pulse, coin_reject, busy};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_underflow t=%0t got credit=%0d vend=%b chg=%b rej=%b busy=%b, no expected frame",
                 $time, a.credit, a.vend, a.chg, a.rej, a.busy);
      end else begin
        e = exp_q.pop_front();
        if (a === e) n_pass++;
        else
          $display("FAIL out_frame t=%0t got credit=%0d vend=%b chg=%b rej=%b busy=%b, expected credit=%0d vend=%b chg=%b rej=%b busy=%b",
                   $time, a.credit, a.vend, a.chg, a.rej, a.busy,
                   e.credit, e.vend, e.chg, e.rej, e.busy);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Power-on reset state
    @(posedge clk);
    #2;
    exp_q.push_back('0);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    drive_step(1'b0, 2'b00, 1'b0, 1'b0);

    // Exact price: 5,10,15 then vend with no change
    repeat (3) coin(COIN_5);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    idle(3);

    // 22 credit: vend then 7 change pulses
    repeat (4) coin(COIN_5);
    coin(COIN_2);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    idle(10);

    // Overflow guard at 30 and 31, bad coin at several credits
    coin(COIN_BAD);
    repeat (6) coin(COIN_5);
    coin(COIN_2);
    coin(COIN_1);
    coin(COIN_1);
    coin(COIN_BAD);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    idle(33);

    // Cancel refund of 6, then select short of price
    coin(COIN_5);
    coin(COIN_1);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    idle(8);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);  // cancel in IDLE has no effect
    repeat (2) coin(COIN_5);
    repeat (2) coin(COIN_2);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    idle(1);
    cyc(1'b1, COIN_1, 1'b1, 1'b1); // cancel wins over select and coin
    idle(16);

    // Select and coin together at exact price
    repeat (3) coin(COIN_5);
    cyc(1'b1, COIN_1, 1'b1, 1'b0);
    idle(2);

    // Coins during VEND and CHANGE are rejected
    repeat (4) coin(COIN_5);
    coin(COIN_2);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    coin(COIN_5);
    coin(COIN_1);
    cyc(1'b0, 2'b00, 1'b1, 1'b1);
    idle(8);

    // Reset mid-change, then new coins accepted
    repeat (4) coin(COIN_5);
    coin(COIN_2);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    idle(4);
    apply_reset();
    coin(COIN_2);
    coin(COIN_5);
    idle(2);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    idle(9);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        cyc(($urandom_range(0, 99) < 45),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 8),
            ($urandom_range(0, 99) < 4));
      end
    end
    idle(35);

    // Drain the two outstanding frames, then close out
    @(negedge clk);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain got %0d frames left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
